divider_4bits_seq: RTL and testbench



---
 rtl/div_pkg.sv | 9 +
 rtl/full_subtracter_4bits.sv | 18 +
 rtl/divider_4bits_seq.sv | 77 +++++++
 tb/tb_divider_4bits_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared width and FSM state encoding for the sequential divider.
package div_pkg;
  localparam int WIDTH = 4;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_subtracter_4bits.sv
// full_subtracter_4bits: ripple-borrow subtractor computing a - b - bin.
module full_subtracter_4bits
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  logic [WIDTH:0] w_b;
  assign w_b[0] = bin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ w_b[i];
    assign w_b[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_b[i]);
  end
  assign bout = w_b[WIDTH];
endmodule

// File: rtl/divider_4bits_seq.sv
// divider_4bits_seq: unsigned restoring divider, one quotient bit per clock.
module divider_4bits_seq
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  state_t           r_state;
  logic [1:0]       r_cnt;
  logic [WIDTH-1:0] r_p, r_q, r_d;
  logic [WIDTH:0]   w_s;
  logic [WIDTH-1:0] w_diff, w_p_nxt, w_q_nxt;
  logic             w_borrow, w_acc;
  // P[4] is always 0 between steps, so only its low bits are stored
  assign w_s = {r_p, r_q[WIDTH-1]};
  full_subtracter_4bits u_sub (
    .a    (w_s[WIDTH-1:0]),
    .b    (r_d),
    .bin  (1'b0),
    .diff (w_diff),
    .bout (w_borrow)
  );
  assign w_acc   = w_s[WIDTH] | ~w_borrow;
  assign w_p_nxt = w_acc ? w_diff : w_s[WIDTH-1:0];
  assign w_q_nxt = {r_q[WIDTH-2:0], w_acc};
  assign busy    = r_state != S_IDLE;
  assign done    = r_state == S_DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          if (divisor != '0) begin
            r_q         <= dividend;
            r_d         <= divisor;
            r_p         <= '0;
            r_cnt       <= '0;
            div_by_zero <= 1'b0;
            r_state     <= S_RUN;
          end else begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_RUN: begin
          r_p   <= w_p_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            quotient  <= w_q_nxt;
            remainder <= w_p_nxt;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_4bits_seq.sv
// tb_divider_4bits_seq: directed and exhaustive checks of the sequential divider.
module tb_divider_4bits_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_4bits_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                         input logic [3:0] er, input logic edz, input int elat);
    int lat, busy_n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_n);
    chk($sformatf("lat %0d/%0d", a, b), 8'(lat), 8'(elat));
    chk($sformatf("busy %0d/%0d", a, b), 8'(busy_n), 8'(elat));
    chk($sformatf("q %0d/%0d", a, b), {4'd0, quotient}, {4'd0, eq});
    chk($sformatf("r %0d/%0d", a, b), {4'd0, remainder}, {4'd0, er});
    chk($sformatf("dz %0d/%0d", a, b), {7'd0, div_by_zero}, {7'd0, edz});
    @(negedge clk);
    chk("done_one_cycle", {7'd0, done}, 8'd0);
    chk("busy_idle", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    int lat, busy_n, dones;
    @(negedge clk);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_q", {4'd0, quotient}, 8'd0);
    chk("rst_r", {4'd0, remainder}, 8'd0);
    chk("rst_dz", {7'd0, div_by_zero}, 8'd0);
    rst = 1'b0;

    run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5);
    run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
    run_div(4'd2, 4'd7, 4'd0, 4'd2, 1'b0, 5);
    run_div(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5);
    run_div(4'd8, 4'd9, 4'd0, 4'd8, 1'b0, 5);
    run_div(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1);
    run_div(4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 5);

    // start pulsed mid-run must be dropped
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd5; divisor = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_n);
    chk("ign_lat", 8'(lat), 8'd3);
    chk("ign_q", {4'd0, quotient}, 8'd3);
    chk("ign_r", {4'd0, remainder}, 8'd2);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ign_extra_done", 8'(dones), 8'd0);

    // start held high: re-accepted after one IDLE cycle
    dividend = 4'd6; divisor = 4'd2; start = 1'b1;
    @(negedge clk);
    wait_done(lat, busy_n);
    chk("held1_lat", 8'(lat), 8'd5);
    chk("held1_q", {4'd0, quotient}, 8'd3);
    dividend = 4'd11; divisor = 4'd3;
    @(negedge clk);
    chk("held_idle_gap", {7'd0, busy}, 8'd0);
    @(negedge clk);
    wait_done(lat, busy_n);
    start = 1'b0;
    chk("held2_lat", 8'(lat), 8'd5);
    chk("held2_q", {4'd0, quotient}, 8'd3);
    chk("held2_r", {4'd0, remainder}, 8'd2);
    @(negedge clk);

    // async reset during the second RUN cycle
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_q", {4'd0, quotient}, 8'd0);
    chk("mid_rst_r", {4'd0, remainder}, 8'd0);
    chk("mid_rst_dz", {7'd0, div_by_zero}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mid_rst_no_done", 8'(dones), 8'd0);
    run_div(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 5);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) run_div(4'(a), 4'd0, 4'hF, 4'(a), 1'b1, 1);
        else run_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 5);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
